// File: rtl/sevseg_pkg.sv
// Shared definitions for the seven-segment scan driver: segment encoding,
// blank pattern and slot state type.
package sevseg_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic {ST_ON, ST_GUARD} slot_state_e;

  // Active-low {a,b,c,d,e,f,g} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b0000001;
      4'h1: s = 7'b1001111;
      4'h2: s = 7'b0010010;
      4'h3: s = 7'b0000110;
      4'h4: s = 7'b1001100;
      4'h5: s = 7'b0100100;
      4'h6: s = 7'b0100000;
      4'h7: s = 7'b0001111;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0000100;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b1100000;
      4'hC: s = 7'b0110001;
      4'hD: s = 7'b1000010;
      4'hE: s = 7'b0110000;
      default: s = 7'b0111000;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/sevseg_scan_driver.sv
// Time-multiplexed 8-digit common-anode display scanner with frame snapshot,
// digit mask, decimal points, brightness PWM and guard tick. Optional
// leading-zero blanking is enabled by defining SEVSEG_LZB_EN.
module sevseg_scan_driver
  import sevseg_pkg::*;
#(
  parameter int NDIGITS    = 8,
  parameter int SLOT_TICKS = 16,
  parameter int BRT_W      = 4
) (
  input  logic                   clk_7seg,
  input  logic                   Rst,
  input  logic [4*NDIGITS-1:0]   value_in,
  input  logic [NDIGITS-1:0]     dp_in,
  input  logic [NDIGITS-1:0]     digit_mask,
  input  logic [BRT_W-1:0]       brightness,
  output logic [NDIGITS-1:0]     an,
  output logic [6:0]             sev_out,
  output logic                   dp,
  output logic                   frame_done
);

  localparam int TW = $clog2(SLOT_TICKS);
  localparam int DW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
  localparam logic [TW:0] TMAX = (TW+1)'(SLOT_TICKS - 1);

  logic [TW-1:0]          tick_q;
  logic [DW-1:0]          digit_q;
  logic [4*NDIGITS-1:0]   value_s;
  logic [NDIGITS-1:0]     dp_s;
  logic [NDIGITS-1:0]     mask_s;
  logic [BRT_W-1:0]       brt_s;

  logic                   snap;
  logic                   tick_last;
  logic                   frame_last;
  logic [4*NDIGITS-1:0]   value_e;
  logic [NDIGITS-1:0]     dp_e;
  logic [NDIGITS-1:0]     mask_e;
  logic [BRT_W-1:0]       brt_e;
  logic [TW:0]            brt_x;
  logic [TW:0]            on_ticks;
  slot_state_e            slot_st;
  logic [3:0]             nib;
  logic                   lzb_cur;
  logic                   lit;
  logic [NDIGITS-1:0]     an_n;
  logic [6:0]             sev_n;
  logic                   dp_n;

  // The snapshot edge drives the outputs from the freshly sampled inputs so
  // the first slot of a frame already reflects the new shadow contents.
  always_comb begin
    snap       = (digit_q == '0) && (tick_q == '0);
    tick_last  = (tick_q == TW'(SLOT_TICKS - 1));
    frame_last = tick_last && (digit_q == DW'(NDIGITS - 1));
    value_e    = snap ? value_in   : value_s;
    dp_e       = snap ? dp_in      : dp_s;
    mask_e     = snap ? digit_mask : mask_s;
    brt_e      = snap ? brightness : brt_s;
    brt_x      = (TW+1)'(brt_e);
    on_ticks   = (brt_x > TMAX) ? TMAX : brt_x;
    slot_st    = ({1'b0, tick_q} < on_ticks) ? ST_ON : ST_GUARD;
    nib        = value_e[digit_q*4 +: 4];
`ifdef SEVSEG_LZB_EN
    lzb_cur    = (digit_q != '0) && ((value_e >> (digit_q*4)) == '0);
`else
    lzb_cur    = 1'b0;
`endif
    lit        = mask_e[digit_q] && (!lzb_cur || dp_e[digit_q]);
    an_n       = '1;
    sev_n      = SEG_BLANK;
    dp_n       = 1'b1;
    if (slot_st == ST_ON) begin
      an_n  = lit ? ~(NDIGITS'(1) << digit_q) : '1;
      sev_n = lzb_cur ? SEG_BLANK : hex7(nib);
      dp_n  = ~dp_e[digit_q];
    end
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      tick_q     <= '0;
      digit_q    <= '0;
      value_s    <= '0;
      dp_s       <= '0;
      mask_s     <= '0;
      brt_s      <= '0;
      an         <= '1;
      sev_out    <= SEG_BLANK;
      dp         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      tick_q <= tick_q + 1'b1;
      if (tick_last)
        digit_q <= (digit_q == DW'(NDIGITS - 1)) ? '0 : digit_q + 1'b1;
      if (snap) begin
        value_s <= value_in;
        dp_s    <= dp_in;
        mask_s  <= digit_mask;
        brt_s   <= brightness;
      end
      an         <= an_n;
      sev_out    <= sev_n;
      dp         <= dp_n;
      frame_done <= frame_last;
    end
  end

endmodule
